// File: rtl/mullo_issue_ctrl_if.sv
// Operand-in and result-out valid/ready channels of the low-half multiplier issue stage.
interface mullo_issue_ctrl_if #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_c;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_tag
    );
endinterface

// File: rtl/mullo_issue_ctrl.sv
// Issue/collect stage around a fixed-latency, non-stallable low-half multiplier.
// Credits cover in-flight ops plus buffered results, so the result FIFO can never overflow.
module mullo_issue_ctrl #(
    parameter int unsigned WIDTH      = 256,
    parameter int unsigned LAT        = 9,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mullo_issue_ctrl_if.slave           io,
    output logic [WIDTH-1:0]            mul_a,
    output logic [WIDTH-1:0]            mul_b,
    input  logic [WIDTH-1:0]            mul_c,
    output logic [$clog2(FIFO_DEPTH):0] occupancy
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned OCC_W = AW + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] c;
    } entry_t;

    logic             accept;
    logic             pop;
    logic             fifo_wr;
    logic             fifo_full;
    logic [LAT:0]     sh_valid;
    logic [TAG_W-1:0] sh_tag [LAT+1];
    entry_t           mem [FIFO_DEPTH];
    entry_t           wr_entry;
    entry_t           head_n;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_n;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [OCC_W-1:0] occ_n;

    assign accept   = io.in_valid && io.in_ready;
    assign pop      = io.out_valid && io.out_ready;
    assign fifo_wr  = sh_valid[LAT];
    assign wr_entry = {sh_tag[LAT], mul_c};

    // Shadow pipe mirrors the multiplier latency; it never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_valid <= '0;
            for (int unsigned i = 0; i <= LAT; i++) sh_tag[i] <= '0;
        end else begin
            sh_valid  <= {sh_valid[LAT-1:0], accept};
            sh_tag[0] <= io.in_tag;
            for (int unsigned i = 1; i <= LAT; i++) sh_tag[i] <= sh_tag[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= io.in_a;
            mul_b <= io.in_b;
        end
    end

    // Next pointers, next head (bypassing a write into an otherwise empty FIFO) and credits.
    always_comb begin
        wr_ptr_n  = wr_ptr + PTR_W'(fifo_wr);
        rd_ptr_n  = rd_ptr + PTR_W'(pop);
        fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        head_n    = mem[rd_ptr_n[AW-1:0]];
        if (fifo_wr && (rd_ptr_n == wr_ptr)) head_n = wr_entry;
        occ_n = occupancy;
        if (accept && !pop)      occ_n = occupancy + OCC_W'(1);
        else if (pop && !accept) occ_n = occupancy - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
            io.out_c     <= '0;
            io.out_tag   <= '0;
        end else begin
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            occupancy    <= occ_n;
            io.in_ready  <= (occ_n < OCC_W'(FIFO_DEPTH));
            io.out_valid <= (wr_ptr_n != rd_ptr_n);
            if (wr_ptr_n != rd_ptr_n) begin
                io.out_c   <= head_n.c;
                io.out_tag <= head_n.tag;
            end
        end
    end

    write_never_full: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wr && fifo_full));

endmodule

// File: tb/tb_mullo_issue_ctrl.sv
// Directed bench for mullo_issue_ctrl with a behavioural fixed-latency multiplier per instance.
module tb_mullo_issue_ctrl;
    localparam int unsigned W     = 256;
    localparam int unsigned WW    = 300;
    localparam int unsigned LAT   = 9;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned OCC_W = 5;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     c;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    mullo_issue_ctrl_if #(.WIDTH(W),  .TAG_W(TAG_W)) bus ();
    mullo_issue_ctrl_if #(.WIDTH(WW), .TAG_W(TAG_W)) bus_w ();

    logic [W-1:0]     mul_a, mul_b, mul_c;
    logic [WW-1:0]    wmul_a, wmul_b, wmul_c;
    logic [OCC_W-1:0] occupancy, w_occupancy;

    mullo_issue_ctrl #(.WIDTH(W), .LAT(LAT), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .io(bus.slave),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .occupancy(occupancy)
    );

    mullo_issue_ctrl #(.WIDTH(WW), .LAT(LAT), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst_n(rst_n), .io(bus_w.slave),
        .mul_a(wmul_a), .mul_b(wmul_b), .mul_c(wmul_c), .occupancy(w_occupancy)
    );

    // Multiplier models: product of operands seen in a cycle appears LAT cycles later.
    logic [W-1:0]  mpipe  [LAT];
    logic [WW-1:0] wmpipe [LAT];
    always @(posedge clk) begin
        mpipe[0]  <= W'(mul_a * mul_b);
        wmpipe[0] <= WW'(wmul_a * wmul_b);
        for (int i = 1; i < int'(LAT); i++) begin
            mpipe[i]  <= mpipe[i-1];
            wmpipe[i] <= wmpipe[i-1];
        end
    end
    assign mul_c  = mpipe[LAT-1];
    assign wmul_c = wmpipe[LAT-1];

    always @(posedge clk) cycle <= cycle + 1;

    // Records accepted ops (with their expected product) and popped results.
    res_t exp_q[$];
    res_t got_q[$];
    int   got_cyc[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back({bus.in_tag, W'(bus.in_a * bus.in_b)});
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back({bus.out_tag, bus.out_c});
                got_cyc.push_back(cycle);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TAG_W-1:0] t);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = t;
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic test_reset();
        #22;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        checks++;
        if (bus.out_c !== '0) begin errors++; $display("FAIL reset_out_c: got %0h want 0", bus.out_c); end
        checks++;
        if (bus.out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %0h want 0", bus.out_tag); end
        checks++;
        if (mul_a !== '0 || mul_b !== '0) begin errors++; $display("FAIL reset_mul_ab: got %0h/%0h want 0/0", mul_a, mul_b); end
        checks++;
        if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        checks++;
        if (w_occupancy !== '0 || bus_w.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_wide: occ %0d ready %0b want 0/1", w_occupancy, bus_w.in_ready);
        end
        checks++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int first;
        logic [W-1:0] c;
        logic [TAG_W-1:0] t;
        first = -1;
        c = '0;
        t = '0;
        clear_q();
        bus.out_ready = 1'b1;
        drive(1'b1, W'(3), W'(5), 4'd7);
        tick();
        drive(1'b0, '0, '0, '0);
        for (int cy = 1; cy <= 25; cy++) begin
            @(negedge clk);
            if (bus.out_valid && first < 0) begin first = cy; c = bus.out_c; t = bus.out_tag; end
            tick();
        end
        if (first != 11) begin errors++; $display("FAIL single_latency: got cycle %0d want 11", first); end
        checks++;
        if (c !== W'(15)) begin errors++; $display("FAIL single_out_c: got %0d want 15", c); end
        checks++;
        if (t !== 4'd7) begin errors++; $display("FAIL single_out_tag: got %0d want 7", t); end
        checks++;
        if (occupancy !== '0) begin errors++; $display("FAIL single_occ_drained: got %0d want 0", occupancy); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int drops;
        drops = 0;
        clear_q();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, rand_w(), rand_w(), TAG_W'(i));
            @(negedge clk);
            if (bus.in_ready !== 1'b1) drops++;
            tick();
        end
        drive(1'b0, '0, '0, '0);
        for (int k = 0; k < 40 && got_q.size() < 32; k++) tick();
        if (drops != 0) begin errors++; $display("FAIL b2b_in_ready: got %0d low cycles want 0", drops); end
        checks++;
        if (got_q.size() != 32) begin errors++; $display("FAIL b2b_count: got %0d want 32", got_q.size()); end
        checks++;
        if (got_q.size() == 32 && got_cyc[31] - got_cyc[0] != 31) begin
            errors++; $display("FAIL b2b_consecutive: got span %0d want 31", got_cyc[31] - got_cyc[0]);
        end
        checks++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_result[%0d]: got tag %0d c %0h want tag %0d c %0h",
                                   i, got_q[i].tag, got_q[i].c, exp_q[i].tag, exp_q[i].c);
            end
            checks++;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] head0;
        clear_q();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, rand_w(), rand_w(), TAG_W'(k));
            tick();
        end
        @(negedge clk);
        head0 = bus.out_c;
        if (exp_q.size() != 16) begin errors++; $display("FAIL bp_accepts: got %0d want 16", exp_q.size()); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b want 0", bus.in_ready); end
        checks++;
        if (occupancy !== OCC_W'(16)) begin errors++; $display("FAIL bp_occupancy: got %0d want 16", occupancy); end
        checks++;
        if (bus.out_valid !== 1'b1 || got_q.size() != 0) begin
            errors++; $display("FAIL bp_stalled_head: out_valid %0b pops %0d want 1/0", bus.out_valid, got_q.size());
        end
        checks++;
        if (exp_q.size() > 0 && head0 !== exp_q[0].c) begin
            errors++; $display("FAIL bp_head_value: got %0h want %0h", head0, exp_q[0].c);
        end
        checks++;
        tick();
        tick();
        if (bus.out_c !== head0) begin errors++; $display("FAIL bp_head_hold: got %0h want %0h", bus.out_c, head0); end
        checks++;
    endtask

    task automatic test_full_stream();
        int bad_occ, bad_ready;
        bad_occ   = 0;
        bad_ready = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, rand_w(), rand_w(), TAG_W'(k + 3));
            @(negedge clk);
            if (bus.in_ready !== (occupancy < OCC_W'(DEPTH)) || occupancy > OCC_W'(DEPTH)) bad_ready++;
            tick();
            if (occupancy !== OCC_W'(exp_q.size() - got_q.size())) bad_occ++;
        end
        drive(1'b0, '0, '0, '0);
        for (int k = 0; k < 80 && (occupancy != 0 || got_q.size() != exp_q.size()); k++) tick();
        if (bad_ready != 0) begin errors++; $display("FAIL full_in_ready: got %0d bad cycles want 0", bad_ready); end
        checks++;
        if (bad_occ != 0) begin errors++; $display("FAIL full_occupancy: got %0d bad cycles want 0", bad_occ); end
        checks++;
        if (exp_q.size() <= 40) begin errors++; $display("FAIL full_accepts: got %0d want >40", exp_q.size()); end
        checks++;
        if (got_q.size() != exp_q.size() || occupancy !== '0) begin
            errors++; $display("FAIL full_drain: got %0d pops occ %0d want %0d pops occ 0",
                               got_q.size(), occupancy, exp_q.size());
        end
        checks++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL full_result[%0d]: got tag %0d c %0h want tag %0d c %0h",
                                   i, got_q[i].tag, got_q[i].c, exp_q[i].tag, exp_q[i].c);
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        int stale;
        stale = 0;
        clear_q();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, rand_w(), rand_w(), TAG_W'(i));
            tick();
        end
        drive(1'b0, '0, '0, '0);
        repeat (5) tick();
        @(negedge clk);
        if (occupancy !== OCC_W'(8) || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_before: occ %0d out_valid %0b want 8/1", occupancy, bus.out_valid);
        end
        checks++;
        rst_n = 1'b0;
        #1;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %0b want 0", bus.out_valid); end
        checks++;
        if (occupancy !== '0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_occ: occ %0d ready %0b want 0/1", occupancy, bus.in_ready);
        end
        checks++;
        tick();
        tick();
        rst_n = 1'b1;
        clear_q();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || occupancy !== '0) stale++;
            tick();
        end
        if (stale != 0) begin errors++; $display("FAIL rstmid_stale: got %0d bad cycles want 0", stale); end
        checks++;
    endtask

    task automatic test_wide();
        int n, first;
        logic [WW-1:0] ones;
        n = 0;
        first = -1;
        ones = '1;
        bus_w.out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            bus_w.in_valid = (c < 16);
            bus_w.in_a     = ones;
            bus_w.in_b     = ones;
            bus_w.in_tag   = TAG_W'(c);
            @(negedge clk);
            if (bus_w.out_valid) begin
                if (first < 0) first = c;
                if (bus_w.out_c !== WW'(1) || bus_w.out_tag !== TAG_W'(n)) begin
                    errors++; $display("FAIL wide_result[%0d]: got c %0h tag %0d want c 1 tag %0d",
                                       n, bus_w.out_c, bus_w.out_tag, n);
                end
                checks++;
                n++;
            end
            tick();
        end
        bus_w.in_valid = 1'b0;
        if (n != 16) begin errors++; $display("FAIL wide_count: got %0d want 16", n); end
        checks++;
        if (first != 11) begin errors++; $display("FAIL wide_latency: got cycle %0d want 11", first); end
        checks++;
    endtask

    initial begin
        drive(1'b0, '0, '0, '0);
        bus.out_ready   = 1'b1;
        bus_w.in_valid  = 1'b0;
        bus_w.in_a      = '0;
        bus_w.in_b      = '0;
        bus_w.in_tag    = '0;
        bus_w.out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full_stream();
        test_reset_mid();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
